cga_hdmi_rx: RTL and testbench

//  Receive end of the CGA parallel HDMI-transmitter bus: samples RGB/G-int/sync/DE pins, undoes brown (index 6) remap

---
 rtl/cga_hdmi_rx_if.sv | 37 +++
 rtl/cga_hdmi_rx.sv | 218 +++++++++++++++++++++
 tb/tb_cga_hdmi_rx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cga_hdmi_rx_if.sv
// Pin and status bundle between a CGA parallel HDMI source and the cga_hdmi_rx receiver.
interface cga_hdmi_rx_if #(
    parameter int HCNT_W = 11,
    parameter int VCNT_W = 10
);
    logic              hdmi_red;
    logic              hdmi_grn;
    logic              hdmi_blu;
    logic              hdmi_int;
    logic              hdmi_grn_int;
    logic              hdmi_hs;
    logic              hdmi_vs;
    logic              hdmi_de;
    logic [3:0]        video;
    logic              display_enable;
    logic              hsync;
    logic              vsync;
    logic              code_err;
    logic [HCNT_W-1:0] h_total;
    logic [HCNT_W-1:0] h_active;
    logic [VCNT_W-1:0] v_active;
    logic              locked;
    logic              hs_pol;
    logic              vs_pol;

    modport master (
        output hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int, hdmi_hs, hdmi_vs, hdmi_de,
        input  video, display_enable, hsync, vsync, code_err,
        input  h_total, h_active, v_active, locked, hs_pol, vs_pol
    );

    modport slave (
        input  hdmi_red, hdmi_grn, hdmi_blu, hdmi_int, hdmi_grn_int, hdmi_hs, hdmi_vs, hdmi_de,
        output video, display_enable, hsync, vsync, code_err,
        output h_total, h_active, v_active, locked, hs_pol, vs_pol
    );
endinterface

// File: rtl/cga_hdmi_rx.sv
// CGA parallel HDMI receiver: pin decode back to RGBI, sync normalisation, line/frame timing and lock.
// Optional macro CGA_HDMI_RX_POL_DETECT_EN enables sync polarity detection at DE rising edges.
module cga_hdmi_rx #(
    parameter int HCNT_W = 11,
    parameter int VCNT_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    cga_hdmi_rx_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [HCNT_W-1:0] HONE = {{(HCNT_W-1){1'b0}}, 1'b1};

    logic [1:0] rst_sync;
    logic       rst_i;

    // Assert immediately, release two clocks after the pin drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_i = rst_sync[1];

    logic red_p1, grn_p1, blu_p1, int_p1, gint_p1, hs_p1, vs_p1, de_p1;

    // Stage 1: pin capture
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            {red_p1, grn_p1, blu_p1, int_p1, gint_p1, hs_p1, vs_p1, de_p1} <= '0;
        end else begin
            red_p1  <= bus.hdmi_red;
            grn_p1  <= bus.hdmi_grn;
            blu_p1  <= bus.hdmi_blu;
            int_p1  <= bus.hdmi_int;
            gint_p1 <= bus.hdmi_grn_int;
            hs_p1   <= bus.hdmi_hs;
            vs_p1   <= bus.hdmi_vs;
            de_p1   <= bus.hdmi_de;
        end
    end

    logic hs_pol_r, vs_pol_r, pol_chg;
`ifdef CGA_HDMI_RX_POL_DETECT_EN
    logic de_prev;
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            de_prev  <= 1'b0;
            hs_pol_r <= 1'b0;
            vs_pol_r <= 1'b0;
        end else begin
            de_prev <= de_p1;
            if (de_p1 && !de_prev) begin
                hs_pol_r <= hs_p1;
                vs_pol_r <= vs_p1;
            end
        end
    end
    assign pol_chg = de_p1 & ~de_prev & ((hs_p1 != hs_pol_r) | (vs_p1 != vs_pol_r));
`else
    assign hs_pol_r = 1'b0;
    assign vs_pol_r = 1'b0;
    assign pol_chg  = 1'b0;
`endif

    logic hs_n, vs_n, brown;
    assign hs_n  = hs_p1 ^ hs_pol_r;
    assign vs_n  = vs_p1 ^ vs_pol_r;
    assign brown = red_p1 & ~grn_p1 & ~blu_p1 & ~int_p1 & gint_p1;

    logic [3:0] video_p2;
    logic       de_p2, hs_p2, vs_p2, err_p2;

    // Stage 2: decode and normalised sync outputs
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            video_p2 <= '0;
            {de_p2, hs_p2, vs_p2, err_p2} <= '0;
        end else begin
            video_p2 <= brown ? 4'b0110 : {int_p1, red_p1, grn_p1, blu_p1};
            de_p2    <= de_p1;
            hs_p2    <= hs_n;
            vs_p2    <= vs_n;
            err_p2   <= de_p1 & ~brown & (gint_p1 != int_p1);
        end
    end

    logic              hs_prev, vs_prev, line_ok;
    logic [HCNT_W-1:0] hcnt, decnt, h_meas, line_act;
    logic [VCNT_W-1:0] vcnt;
    logic [HCNT_W-1:0] h_meas_nx, line_act_nx;
    logic [VCNT_W-1:0] vcnt_nx;
    logic              hs_rise, vs_rise, sat_evt;

    assign hs_rise = hs_n & ~hs_prev;
    assign vs_rise = vs_n & ~vs_prev;
    assign sat_evt = (hcnt == '1) & ~hs_rise;

    // Line close is folded in first so a coincident vs edge snapshots the completed line.
    always_comb begin
        h_meas_nx   = h_meas;
        line_act_nx = line_act;
        vcnt_nx     = vcnt;
        if (hs_rise) begin
            if (line_ok) h_meas_nx = hcnt;
            if (decnt != '0) begin
                line_act_nx = decnt;
                vcnt_nx     = (vcnt == '1) ? vcnt : vcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            line_ok  <= 1'b0;
            hcnt     <= '0;
            decnt    <= '0;
            h_meas   <= '0;
            line_act <= '0;
            vcnt     <= '0;
        end else begin
            hs_prev  <= hs_n;
            vs_prev  <= vs_n;
            h_meas   <= h_meas_nx;
            line_act <= line_act_nx;
            vcnt     <= vs_rise ? '0 : vcnt_nx;
            if (hs_rise)            hcnt <= HONE;
            else if (hcnt != '1)    hcnt <= hcnt + 1'b1;
            if (hs_rise)            decnt <= de_p1 ? HONE : '0;
            else if (de_p1 && decnt != '1) decnt <= decnt + 1'b1;
            if (sat_evt || pol_chg) line_ok <= 1'b0;
            else if (hs_rise)       line_ok <= 1'b1;
        end
    end

    state_t            state, state_nx;
    logic              ref_ld, ref_clr, out_ld, snap_match;
    logic [HCNT_W-1:0] ref_h, ref_a;
    logic [VCNT_W-1:0] ref_v;

    assign snap_match = (h_meas_nx == ref_h) && (line_act_nx == ref_a) && (vcnt_nx == ref_v);

    always_comb begin
        state_nx = state;
        ref_ld   = 1'b0;
        ref_clr  = 1'b0;
        out_ld   = 1'b0;
        if (sat_evt || pol_chg) begin
            state_nx = SEARCH;
            ref_clr  = 1'b1;
        end else if (vs_rise) begin
            case (state)
                SEARCH: begin
                    state_nx = MEASURE;
                    ref_ld   = 1'b1;
                end
                MEASURE: begin
                    out_ld = 1'b1;
                    if (snap_match) state_nx = LOCKED;
                    else            ref_ld   = 1'b1;
                end
                LOCKED: begin
                    out_ld = 1'b1;
                    if (!snap_match) begin
                        state_nx = MEASURE;
                        ref_ld   = 1'b1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    logic [HCNT_W-1:0] h_total_r, h_active_r;
    logic [VCNT_W-1:0] v_active_r;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= SEARCH;
            ref_h      <= '0;
            ref_a      <= '0;
            ref_v      <= '0;
            h_total_r  <= '0;
            h_active_r <= '0;
            v_active_r <= '0;
        end else begin
            state <= state_nx;
            if (ref_clr) begin
                ref_h <= '0;
                ref_a <= '0;
                ref_v <= '0;
            end else if (ref_ld) begin
                ref_h <= h_meas_nx;
                ref_a <= line_act_nx;
                ref_v <= vcnt_nx;
            end
            if (out_ld) begin
                h_total_r  <= h_meas_nx;
                h_active_r <= line_act_nx;
                v_active_r <= vcnt_nx;
            end
        end
    end

    assign bus.video          = video_p2;
    assign bus.display_enable = de_p2;
    assign bus.hsync          = hs_p2;
    assign bus.vsync          = vs_p2;
    assign bus.code_err       = err_p2;
    assign bus.h_total        = h_total_r;
    assign bus.h_active       = h_active_r;
    assign bus.v_active       = v_active_r;
    assign bus.locked         = (state == LOCKED);
    assign bus.hs_pol         = hs_pol_r;
    assign bus.vs_pol         = vs_pol_r;
endmodule

// File: tb/tb_cga_hdmi_rx.sv
// Scoreboard bench for cga_hdmi_rx: pixel decode and per-frame timing/lock reports checked by monitors.
module tb_cga_hdmi_rx;
    localparam int HW = 11;
    localparam int VW = 10;
`ifdef CGA_HDMI_RX_POL_DETECT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    // Scaled-down raster: 200-clock lines, 16-clock hsync, DE on lines 4..23, vsync at line 26, 30 lines.
    localparam int LCLK  = 200;
    localparam int HSW   = 16;
    localparam int DE0   = 40;
    localparam int LINES = 30;
    localparam int DL0   = 4;
    localparam int DL1   = 24;
    localparam int VSL   = 26;

    typedef struct packed {
        logic [3:0] video;
        logic       err;
    } pix_t;

    typedef struct packed {
        logic [HW-1:0] ht;
        logic [HW-1:0] ha;
        logic [VW-1:0] va;
        logic          lk;
    } frm_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cga_hdmi_rx_if #(.HCNT_W(HW), .VCNT_W(VW)) bus ();
    cga_hdmi_rx #(.HCNT_W(HW), .VCNT_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pix_t pix_q[$];
    frm_t frm_q[$];
    pix_t mon_p;
    frm_t mon_f;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   pix_en = 1'b0;
    bit   frm_en = 1'b0;
    logic vs_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pins(input logic r, g, b, i, gi, hs, vs, de);
        bus.hdmi_red     = r;
        bus.hdmi_grn     = g;
        bus.hdmi_blu     = b;
        bus.hdmi_int     = i;
        bus.hdmi_grn_int = gi;
        bus.hdmi_hs      = hs ^ INV;
        bus.hdmi_vs      = vs ^ INV;
        bus.hdmi_de      = de;
    endtask

    // Transmitter-side encoding: brown goes out as red + green-intensity only.
    task automatic drive_idx(input logic [3:0] idx, input logic hs, vs, de);
        if (idx == 4'd6) pins(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, hs, vs, de);
        else             pins(idx[2], idx[1], idx[0], idx[3], idx[3], hs, vs, de);
    endtask

    task automatic send_frame(input int first, input int de_len, input frm_t exp);
        logic       de;
        logic [3:0] idx;
        for (int ln = first; ln < LINES; ln++) begin
            for (int c = 0; c < LCLK; c++) begin
                de  = (ln >= DL0) && (ln < DL1) && (c >= DE0) && (c < DE0 + de_len);
                idx = de ? c[3:0] : 4'd0;
                drive_idx(idx, c < HSW, (ln >= VSL) && (ln < VSL + 2), de);
                if (ln == VSL && c == 0) frm_q.push_back(exp);
                clk1();
            end
        end
    endtask

    always @(negedge clk) begin
        if (pix_en && bus.display_enable) begin
            if (pix_q.size() == 0) begin
                n_chk++;
                $display("FAIL pix_unexpected: got DE output video %0d, expected no output", bus.video);
            end else begin
                mon_p = pix_q.pop_front();
                chk("video", {28'd0, bus.video}, {28'd0, mon_p.video});
                chk("code_err", {31'd0, bus.code_err}, {31'd0, mon_p.err});
            end
        end
        if (frm_en && bus.vsync && !vs_q) begin
            if (frm_q.size() == 0) begin
                n_chk++;
                $display("FAIL frame_unexpected: got vsync rise, expected none");
            end else begin
                mon_f = frm_q.pop_front();
                chk("h_total",  {21'd0, bus.h_total},  {21'd0, mon_f.ht});
                chk("h_active", {21'd0, bus.h_active}, {21'd0, mon_f.ha});
                chk("v_active", {22'd0, bus.v_active}, {22'd0, mon_f.va});
                chk("locked",   {31'd0, bus.locked},   {31'd0, mon_f.lk});
            end
        end
        vs_q <= bus.vsync;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) clk1();
        chk("rst_video",    {28'd0, bus.video}, 32'd0);
        chk("rst_de",       {31'd0, bus.display_enable}, 32'd0);
        chk("rst_vsync",    {31'd0, bus.vsync}, 32'd0);
        chk("rst_h_total",  {21'd0, bus.h_total}, 32'd0);
        chk("rst_locked",   {31'd0, bus.locked}, 32'd0);
        chk("rst_hs_pol",   {31'd0, bus.hs_pol}, 32'd0);
        reset = 1'b0;
        repeat (4) clk1();

        pix_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive_idx(k[3:0], 1'b0, 1'b0, 1'b1);
            pix_q.push_back('{video: k[3:0], err: 1'b0});
            clk1();
        end
        pins(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pix_q.push_back('{video: 4'd6, err: 1'b0});
        clk1();
        pins(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pix_q.push_back('{video: 4'd6, err: 1'b1});
        clk1();
        pins(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_q.push_back('{video: 4'd13, err: 1'b1});
        clk1();
        pins(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) clk1();
        chk("pix_q_drained", pix_q.size(), 32'd0);
        pix_en = 1'b0;
        frm_en = 1'b1;

        send_frame(10, 120, '{ht: 11'd0,   ha: 11'd0,   va: 10'd0,  lk: 1'b0});
        send_frame(0,  120, '{ht: 11'd200, ha: 11'd120, va: 10'd20, lk: 1'b0});
        send_frame(0,  120, '{ht: 11'd200, ha: 11'd120, va: 10'd20, lk: 1'b1});
        send_frame(0,  120, '{ht: 11'd200, ha: 11'd120, va: 10'd20, lk: 1'b1});
        send_frame(0,  60,  '{ht: 11'd200, ha: 11'd60,  va: 10'd20, lk: 1'b0});
        send_frame(0,  60,  '{ht: 11'd200, ha: 11'd60,  va: 10'd20, lk: 1'b1});
        chk("hs_pol", {31'd0, bus.hs_pol}, {31'd0, INV});
        chk("vs_pol", {31'd0, bus.vs_pol}, {31'd0, INV});
        chk("locked_before_stall", {31'd0, bus.locked}, 32'd1);

        pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2100) clk1();
        chk("stall_locked",   {31'd0, bus.locked}, 32'd0);
        chk("stall_h_total",  {21'd0, bus.h_total}, 32'd200);
        chk("stall_v_active", {22'd0, bus.v_active}, 32'd20);

        for (int c = 0; c < 45; c++) begin
            drive_idx(4'd11, c < HSW, 1'b0, c >= DE0);
            clk1();
        end
        chk("pre_rst_video", {28'd0, bus.video}, 32'd11);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_video",    {28'd0, bus.video}, 32'd0);
        chk("mid_rst_de",       {31'd0, bus.display_enable}, 32'd0);
        chk("mid_rst_hsync",    {31'd0, bus.hsync}, 32'd0);
        chk("mid_rst_vsync",    {31'd0, bus.vsync}, 32'd0);
        chk("mid_rst_code_err", {31'd0, bus.code_err}, 32'd0);
        chk("mid_rst_h_total",  {21'd0, bus.h_total}, 32'd0);
        chk("mid_rst_h_active", {21'd0, bus.h_active}, 32'd0);
        chk("mid_rst_v_active", {22'd0, bus.v_active}, 32'd0);
        chk("mid_rst_locked",   {31'd0, bus.locked}, 32'd0);
        chk("mid_rst_hs_pol",   {31'd0, bus.hs_pol}, 32'd0);
        chk("mid_rst_vs_pol",   {31'd0, bus.vs_pol}, 32'd0);
        chk("frm_q_drained", frm_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
